ifetch_unit: RTL and testbench
==============================

Name: ifetch_unit

Overview:
- Initiator side of the instruction-memory interface. Owns the PC, drives the imem request address, captures the returned instruction word and buffers {pc, instr} pairs in a small queue toward decode.
- imem is combinational: imem_rdata corresponds to imem_req_addr in the same cycle.
- Sits between imem and the decode stage; accepts branch/jump redirects from execute.

Parameters:
- XLEN, 32, address/data width.
- RESET_PC, 32'h0000_0000, PC value after reset.
- QDEPTH, 2, fetch queue entries (power of two, >=2).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- fetch_en  in  1  allows new fetches when high.
- imem_req_addr  out  XLEN  address to imem (equals current PC).
- imem_rdata  in  32  instruction from imem for imem_req_addr.
- redirect_valid  in  1  execute requests a PC change this cycle.
- redirect_pc  in  XLEN  target PC; bits [1:0] ignored (forced 0).
- ifq_valid  out  1  head entry valid toward decode.
- ifq_ready  in  1  decode accepts head entry.
- ifq_instr  out  32  head instruction; NOP_INSTR when empty.
- ifq_pc  out  XLEN  head PC; 0 when empty.
- ifq_count  out  $clog2(QDEPTH)+1  occupancy.

Behaviour:
- Reset (async assert, any cycle): pc=RESET_PC, queue emptied, ifq_valid=0, ifq_count=0, ifq_instr=NOP_INSTR, ifq_pc=0. imem_req_addr=RESET_PC. Entries held at reset are discarded with no drain.
- imem_req_addr = pc combinationally; pc[1:0] always 0.
- pop = ifq_valid & ifq_ready. space = (count<QDEPTH) | pop.
- push = fetch_en & space & ~redirect_valid. On push, {pc, imem_rdata} is enqueued at the tail and pc <= pc+4 (mod 2^XLEN; 32'hFFFF_FFFC wraps to 0).
- Full without pop: no push, pc holds, imem_req_addr stable.
- Full with pop in the same cycle: pop and push both occur; count unchanged.
- Empty queue: ifq_valid=0 and ifq_ready is ignored. No bypass: a pushed entry becomes visible at the head in the next cycle. Fetch-to-decode latency is 1 cycle.
- Redirect has priority over push and pop. The queue is flushed (count <= 0), pc <= {redirect_pc[XLEN-1:2], 2'b00}, and no push occurs. The head entry is not consumed, even if ifq_ready=1. Next cycle imem_req_addr = target.
- fetch_en=0: no push, pc holds. Pops and redirects still operate.
- Queue is FIFO order. Pointers wrap modulo QDEPTH. count is never >QDEPTH and never underflows.
- Outputs ifq_* come from head registers, not from imem_rdata, so there is no combinational path from imem_rdata or ifq_ready to ifq_*.

Decomposition:
- Package ifetch_pkg: NOP_INSTR = 32'h0000_0013, RESET_PC default, typedef struct packed fetch_entry_t {logic [XLEN-1:0] pc; logic [31:0] instr;}.
- Sub-module fetch_queue: a parameterised synchronous FIFO of fetch_entry_t with push, pop, flush, count, async active-high rst.
- ifetch_unit holds the PC register, push/redirect arbitration, and the empty-output muxing.

Test Plan:
- Reset: rst=1 mid-stream with 2 entries queued -> ifq_valid=0, ifq_count=0, imem_req_addr=0, ifq_instr=32'h13 immediately, before the next clk edge.
- Streaming: fetch_en=1, ifq_ready=1, imem model returns addr-based words -> decode sees pc 0,4,8,12 on consecutive cycles starting 1 cycle after the first fetch.
- Backpressure: ifq_ready=0 for 5 cycles -> count reaches 2 and stays, imem_req_addr holds at 8. Release ifq_ready -> pc 0,4,8,12 delivered with no gap or duplicate.
- Redirect while full: count=2, redirect_valid=1, redirect_pc=32'h0000_0103, ifq_ready=1 -> next cycle count=0, imem_req_addr=32'h100, then head pc=32'h100.
- Full with simultaneous pop/push: count=2, ifq_ready=1 -> count stays 2, pc advances by 4 each cycle.
- Wrap: redirect to 32'hFFFF_FFF8 -> queued pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.

Source files
------------

// File: rtl/ifetch_pkg.sv
`default_nettype none
// ============================================================================
// ifetch_pkg : shared constants and fetch-queue entry type for ifetch_unit. Rev 1.0
// ============================================================================
package ifetch_pkg;

  localparam int                 FE_XLEN          = 32;
  localparam logic [31:0]        NOP_INSTR        = 32'h0000_0013;
  localparam logic [FE_XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [FE_XLEN-1:0] pc;
    logic [31:0]        instr;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// fetch_queue : synchronous FIFO of fetch entries with flush. Rev 1.0
// ============================================================================
module fetch_queue
  import ifetch_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetch_entry_t  wdata_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam logic [CW-1:0] c_depth = CW'(DEPTH);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          w_push, w_pop;

  // Guard against caller misuse so count can never overflow or underflow.
  assign w_pop  = pop_i & (count_q != '0);
  assign w_push = push_i & ((count_q < c_depth) | w_pop);

  always_comb begin
    count_d = count_q;
    if (w_push && !w_pop)      count_d = count_q + CW'(1);
    else if (!w_push && w_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/ifetch_unit.sv
`default_nettype none
// ============================================================================
// ifetch_unit : PC owner / imem initiator buffering {pc, instr} toward decode. Rev 1.0
// ============================================================================
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter  int              XLEN     = FE_XLEN,
  parameter  logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
  parameter  int              QDEPTH   = 2,
  localparam int              CW       = $clog2(QDEPTH) + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            ifq_valid,
  input  logic            ifq_ready,
  output logic [31:0]     ifq_instr,
  output logic [XLEN-1:0] ifq_pc,
  output logic [CW-1:0]   ifq_count
);

  localparam logic [XLEN-1:0] c_align_mask = {{(XLEN-2){1'b1}}, 2'b00};
  localparam logic [CW-1:0]   c_depth      = CW'(QDEPTH);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            w_pop, w_push, w_space;
  fetch_entry_t    w_wentry, w_head;
  logic [CW-1:0]   w_count;

  // Redirect wins: the head is held (then flushed) even if decode is ready.
  assign w_pop   = ifq_valid & ifq_ready & ~redirect_valid;
  assign w_space = (w_count < c_depth) | w_pop;
  assign w_push  = fetch_en & w_space & ~redirect_valid;

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc & c_align_mask;
    else if (w_push)    pc_d = pc_q + XLEN'(4);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= RESET_PC & c_align_mask;
    else     pc_q <= pc_d;
  end

  assign w_wentry.pc    = pc_q;
  assign w_wentry.instr = imem_rdata;

  fetch_queue #(
    .DEPTH (QDEPTH)
  ) u_fetch_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (redirect_valid),
    .wdata_i (w_wentry),
    .head_o  (w_head),
    .count_o (w_count)
  );

  assign imem_req_addr = pc_q;
  assign ifq_count     = w_count;
  assign ifq_valid     = (w_count != '0);
  assign ifq_instr     = ifq_valid ? w_head.instr : NOP_INSTR;
  assign ifq_pc        = ifq_valid ? w_head.pc    : '0;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
// ============================================================================
// tb_ifetch_unit : directed self-checking bench for ifetch_unit. Rev 1.0
// ============================================================================
module tb_ifetch_unit;

  localparam logic [31:0] c_key = 32'h5A5A_0000;

  logic        clk;
  logic        rst;
  logic        fetch_en;
  logic [31:0] imem_req_addr;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        ifq_valid;
  logic        ifq_ready;
  logic [31:0] ifq_instr;
  logic [31:0] ifq_pc;
  logic [1:0]  ifq_count;

  int checks   = 0;
  int failures = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_en       (fetch_en),
    .imem_req_addr  (imem_req_addr),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ifq_valid      (ifq_valid),
    .ifq_ready      (ifq_ready),
    .ifq_instr      (ifq_instr),
    .ifq_pc         (ifq_pc),
    .ifq_count      (ifq_count)
  );

  // Combinational imem: word is a fixed function of the address.
  assign imem_rdata = imem_req_addr ^ c_key;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [31:0] pc);
    chk({tag, ".valid"}, 32'(ifq_valid), 32'd1);
    chk({tag, ".pc"},    ifq_pc,         pc);
    chk({tag, ".instr"}, ifq_instr,      pc ^ c_key);
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, ".valid"}, 32'(ifq_valid), 32'd0);
    chk({tag, ".count"}, 32'(ifq_count), 32'd0);
    chk({tag, ".instr"}, ifq_instr,      32'h0000_0013);
    chk({tag, ".pc"},    ifq_pc,         32'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst            = 1'b1;
    fetch_en       = 1'b0;
    ifq_ready      = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    #2;
    chk_empty("reset");
    chk("reset.addr", imem_req_addr, 32'h0);
    tick();
    tick();
    rst = 1'b0;

    // Streaming: head pc 0,4,8,12 one cycle after each fetch.
    fetch_en  = 1'b1;
    ifq_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_head($sformatf("stream%0d", k), 32'(4 * k));
      chk($sformatf("stream%0d.count", k), 32'(ifq_count), 32'd1);
      chk($sformatf("stream%0d.addr", k), imem_req_addr, 32'(4 * k + 4));
    end

    // Fill to two entries, then assert reset mid-cycle.
    ifq_ready = 1'b0;
    tick();
    chk("fill.count", 32'(ifq_count), 32'd2);
    chk("fill.addr", imem_req_addr, 32'd20);
    rst = 1'b1;
    #1;
    chk_empty("midrst");
    chk("midrst.addr", imem_req_addr, 32'h0);
    #2;
    rst = 1'b0;

    // Backpressure: five cycles with decode stalled.
    for (int k = 0; k < 5; k++) begin
      tick();
      chk($sformatf("bp%0d.count", k), 32'(ifq_count), (k == 0) ? 32'd1 : 32'd2);
      chk($sformatf("bp%0d.addr", k), imem_req_addr, (k == 0) ? 32'd4 : 32'd8);
    end
    chk_head("bp.head", 32'd0);

    // Release: full with pop+push, count stays 2, pc advances by 4.
    ifq_ready = 1'b1;
    for (int k = 1; k < 4; k++) begin
      tick();
      chk_head($sformatf("rel%0d", k), 32'(4 * k));
      chk($sformatf("rel%0d.count", k), 32'(ifq_count), 32'd2);
      chk($sformatf("rel%0d.addr", k), imem_req_addr, 32'(8 + 4 * k));
    end

    // Redirect while full with misaligned target.
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    chk_empty("redir");
    chk("redir.addr", imem_req_addr, 32'h100);
    tick();
    chk_head("redir.head", 32'h100);
    chk("redir.count", 32'(ifq_count), 32'd1);
    chk("redir.addr2", imem_req_addr, 32'h104);

    // fetch_en low: pop still drains, pc holds, empty ignores ready.
    fetch_en = 1'b0;
    tick();
    chk_empty("fen0a");
    chk("fen0a.addr", imem_req_addr, 32'h104);
    tick();
    chk_empty("fen0b");
    chk("fen0b.addr", imem_req_addr, 32'h104);

    // Wrap at top of address space.
    ifq_ready      = 1'b0;
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    tick();
    redirect_valid = 1'b0;
    chk("wrap.addr0", imem_req_addr, 32'hFFFF_FFF8);
    chk("wrap.count0", 32'(ifq_count), 32'd0);
    tick();
    chk("wrap.addr1", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    chk("wrap.addr2", imem_req_addr, 32'h0);
    chk("wrap.count2", 32'(ifq_count), 32'd2);
    tick();
    chk("wrap.hold", imem_req_addr, 32'h0);
    chk_head("wrap.h0", 32'hFFFF_FFF8);
    ifq_ready = 1'b1;
    tick();
    chk_head("wrap.h1", 32'hFFFF_FFFC);
    chk("wrap.addr3", imem_req_addr, 32'h4);
    tick();
    chk_head("wrap.h2", 32'h0000_0000);
    chk("wrap.count3", 32'(ifq_count), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
